// File: rtl/mmio_console_pkg.sv
// Shared types and register map for the memory-mapped console transmitter.
`timescale 1ns/1ps
package mmio_console_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

  // A STATUS store clears the sticky overflow flag when this data bit is set.
  localparam int OVF_CLEAR_BIT  = 3;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_BUSY_BIT]  = busy;
    w[STAT_OVF_BIT]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mmio_console_tx_if.sv
// CPU data-memory bus as seen by the console: store strobe/address/data and load address/data.
`timescale 1ns/1ps
interface mmio_console_tx_if;

  logic        memory_write_en;
  logic [31:0] memory_write_address;
  logic [31:0] memory_write;
  logic [31:0] memory_read_address;
  logic [31:0] memory_read_data;

  modport master (
    output memory_write_en,
    output memory_write_address,
    output memory_write,
    output memory_read_address,
    input  memory_read_data
  );

  modport slave (
    input  memory_write_en,
    input  memory_write_address,
    input  memory_write,
    input  memory_read_address,
    output memory_read_data
  );

endinterface

// File: rtl/mmio_console_tx_fifo.sv
// Small synchronous byte FIFO with show-ahead read data and a registered occupancy count.
`timescale 1ns/1ps
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A push while full is still accepted when a pop frees a slot on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
    count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/mmio_console_tx.sv
// Console transmitter: decodes CPU stores/loads in its window, queues bytes and sends 8N1 frames.
`timescale 1ns/1ps
module mmio_console_tx
  import mmio_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  mmio_console_tx_if.slave  bus,
  output logic              uart_tx,
  output logic              tx_busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          uart_tx_reg, uart_tx_next;
  logic          tx_busy_reg, tx_busy_next;
  logic          ovf_reg, ovf_next;
  logic [31:0]   rd_data_reg, rd_data_next;

  logic          wr_txdata, wr_status, pop, push_ok;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count, fifo_count_next;
  logic          unused_wdata;

  assign unused_wdata = ^bus.memory_write[31:8];

  assign wr_txdata = bus.memory_write_en && (bus.memory_write_address == BASE_ADDR + TXDATA_OFS);
  assign wr_status = bus.memory_write_en && (bus.memory_write_address == BASE_ADDR + STATUS_OFS);

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_txdata),
    .push_data (bus.memory_write[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_ok         = wr_txdata && (!fifo_full || pop);
  assign fifo_count_next = fifo_count + CW'(push_ok) - CW'(pop);

  // Overflow set wins over a simultaneous clear.
  assign ovf_next = (wr_txdata && fifo_full && !pop) ||
                    (ovf_reg && !(wr_status && bus.memory_write[OVF_CLEAR_BIT]));

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          baud_next  = BAUD_RELOAD;
          state_next = START;
        end
      end
      START: begin
        if (baud_reg == '0) begin
          baud_next    = BAUD_RELOAD;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
      DATA: begin
        if (baud_reg == '0) begin
          baud_next = BAUD_RELOAD;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
      STOP: begin
        if (baud_reg == '0) begin
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_data;
            baud_next  = BAUD_RELOAD;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level and busy flag are computed from next-state values so both outputs come straight from flops.
  always_comb begin
    uart_tx_next = 1'b1;
    case (state_next)
      START:   uart_tx_next = 1'b0;
      DATA:    uart_tx_next = shift_next[0];
      default: uart_tx_next = 1'b1;
    endcase
    tx_busy_next = (state_next != IDLE) || (fifo_count_next != '0);
    rd_data_next = '0;
    if (bus.memory_read_address == BASE_ADDR + STATUS_OFS)
      rd_data_next = status_word(fifo_full, fifo_empty, state_reg != IDLE, ovf_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      uart_tx_reg <= 1'b1;
      tx_busy_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      uart_tx_reg <= uart_tx_next;
      tx_busy_reg <= tx_busy_next;
      ovf_reg     <= ovf_next;
      rd_data_reg <= rd_data_next;
    end
  end

  assign uart_tx              = uart_tx_reg;
  assign tx_busy              = tx_busy_reg;
  assign bus.memory_read_data = rd_data_reg;

endmodule

// File: doc/mmio_console_tx.md
# mmio_console_tx

Memory-mapped console transmitter on the multicycle RV32I core's data-memory bus. It responds to CPU stores in its address window by queueing bytes in a small FIFO and serialising them as 8N1 UART frames on a single pin. It also returns a status word on CPU loads from the same window. It gives programs a hardware output path for the register and store activity the simulation bench otherwise only prints.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_2000: word-aligned base of the 8-byte register window.
- CLKS_PER_BIT, 104: clock cycles per UART bit; minimum 2.
- FIFO_DEPTH, 8: byte entries; power of two.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- memory_write_en  input  1  CPU store strobe, one cycle per store.
- memory_write_address  input  32  store address.
- memory_write  input  32  store data; only [7:0] and bit 3 are used.
- memory_read_address  input  32  load address.
- memory_read_data  output  32  registered load data; reset 0.
- uart_tx  output  1  serial line, idle high; reset 1.
- tx_busy  output  1  shifter is not IDLE or FIFO is non-empty; reset 0.

## Operation
- Decode uses full 32-bit equality and ignores byte lanes.
  - TXDATA = BASE_ADDR+0.
  - STATUS = BASE_ADDR+4.
- Store to TXDATA pushes memory_write[7:0] into the FIFO.
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and the sticky `overflow` flag is set.
  - A push and a pop on the same edge while full are both accepted; the count is unchanged.
- Store to STATUS with bit 3 = 1 clears `overflow`. A clear and a new overflow on the same edge leave `overflow` set.
- STATUS read data:
  - bit0 fifo_full.
  - bit1 fifo_empty.
  - bit2 shifter_busy, meaning state is not IDLE.
  - bit3 overflow.
  - Bits 31:4 read 0.
- Loads from TXDATA or from any address outside the window return 0. Reads have no side effects.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. This pops the byte into the shift register and reloads the baud counter.
  - START: uart_tx = 0 for CLKS_PER_BIT cycles, then → DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index goes 0..7, then → STOP.
  - STOP: uart_tx = 1 for CLKS_PER_BIT cycles. At the end, go → START, popping the next byte if the FIFO is non-empty (no idle gap), else → IDLE.
- Baud counter counts down from CLKS_PER_BIT-1 to 0. Its width is $clog2(CLKS_PER_BIT).
- FIFO count width is $clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- Asserting reset_n low at any time, including mid-frame, immediately does all of the following:
  - uart_tx goes to 1 and the FSM to IDLE.
  - The FIFO empties and `overflow` clears.
  - memory_read_data goes to 0.
  - The partially sent frame is abandoned.

## Timing
- Store latency: a store sampled at edge N is visible in the FIFO count and in STATUS read data at edge N+1.
- Start-of-frame latency: with an empty FIFO and IDLE state, a store at edge N pops at edge N+1. uart_tx falls after edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Load latency: memory_read_data is valid one cycle after memory_read_address is presented, matching the core's synchronous memory.
- uart_tx and tx_busy are registered outputs, glitch-free.

## Structure
- Package mmio_console_pkg:
  - State enum typedef (IDLE/START/DATA/STOP).
  - Register offset constants TXDATA_OFS = 0 and STATUS_OFS = 4.
  - Status bit-position constants.
- Sub-module tx_fifo: synchronous FIFO with push/pop, full/empty and registered count. It is parameterised by width 8 and FIFO_DEPTH.
- The top of mmio_console_tx holds the address decode, status/overflow logic, baud counter and FSM.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
- Reset: reset_n = 0 for 2 cycles → uart_tx = 1, tx_busy = 0, and a STATUS read = 0x0000_0002.
- Single byte: store 0x55 to 0x2000 → uart_tx holds for 4 cycles each: 0, then 1,0,1,0,1,0,1,0, then stop 1. Frame is 40 cycles total. tx_busy drops the cycle after STOP ends.
- Back-to-back: store 0x41 then 0x42 on consecutive cycles → two 40-cycle frames with no idle cycle between STOP and the second START.
- Overflow: 10 stores in 10 cycles → 9 bytes transmitted, because one is popped into the shifter first. The 10th is dropped, and a STATUS read returns bit3 = 1 and bit0 = 1 until a pop. Storing 0x8 to 0x2004 then reads bit3 = 0.
- Decode: store 0xAA to 0x2008 and to 0x1FFC → no FIFO change and uart_tx stays 1. Loads from 0x2000 and 0x3000 return 0.
- Reset mid-frame: deassert reset_n 13 cycles into a frame of 0x00 → uart_tx = 1 immediately. After release, STATUS = 0x0000_0002 and no residual frame is sent.
